// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared types and constants for the pipeline sequencing controller.
// Revision : 1.0
// ============================================================================
package pipe_pkg;

    localparam int REG_AW_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STALL  = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_flush;
        logic exwb_en;
    } strobe_t;

    // Strobe patterns, field order {pc_en, ifid_en, ifid_flush, idex_flush, exwb_en}
    localparam strobe_t c_STB_IDLE    = 5'b00110;
    localparam strobe_t c_STB_RUN     = 5'b11001;
    localparam strobe_t c_STB_HAZARD  = 5'b00011;
    localparam strobe_t c_STB_BRANCH  = 5'b10111;
    localparam strobe_t c_STB_HALTREQ = 5'b00101;
    localparam strobe_t c_STB_DRAIN   = 5'b00111;
    localparam strobe_t c_STB_HALTED  = 5'b00110;

    localparam logic [2:0] c_DRAIN_CNT = 3'd2;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Brief    : Combinational RAW compare of ID sources against EX and WB dests.
// Revision : 1.0
// ============================================================================
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              i_rs_valid,
    input  logic              i_rt_valid,
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rt,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_regwrite,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_regwrite,
    output logic              o_hz_ex,
    output logic              o_hz_wb
);

    assign o_hz_ex = i_ex_regwrite &&
                     ((i_rs_valid && (i_rs == i_ex_rd)) || (i_rt_valid && (i_rt == i_ex_rd)));
    assign o_hz_wb = i_wb_regwrite &&
                     ((i_rs_valid && (i_rs == i_wb_rd)) || (i_rt_valid && (i_rt == i_wb_rd)));

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush/drain sequencer; optional perf counters under
//            PIPE_HAZARD_CTRL_PERF_EN.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int HAZARD_STALL = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              id_rs_valid,
    input  logic              id_rt_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              br_taken,
    input  logic              halt_req,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exwb_en,
    output logic [2:0]        state_o,
    output logic              halted,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    localparam logic [2:0] c_HZ_CNT = 3'(HAZARD_STALL - 1);
    localparam logic [2:0] c_FL_CNT = 3'(FLUSH_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_pend, w_pend_nxt;
    strobe_t    w_stb;
    logic       w_hz_ex, w_hz_wb;
    logic       w_hz_cycle, w_br_cycle;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
        .i_rs_valid    (id_rs_valid),
        .i_rt_valid    (id_rt_valid),
        .i_rs          (id_rs),
        .i_rt          (id_rt),
        .i_ex_rd       (ex_rd),
        .i_ex_regwrite (ex_regwrite),
        .i_wb_rd       (wb_rd),
        .i_wb_regwrite (wb_regwrite),
        .o_hz_ex       (w_hz_ex),
        .o_hz_wb       (w_hz_wb)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_stb       = c_STB_IDLE;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hz_cycle  = 1'b0;
        w_br_cycle  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                // A branch resolving in EX is older than the stalled ID instruction
                if (br_taken) begin
                    w_stb       = c_STB_BRANCH;
                    w_br_cycle  = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 3'd0;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt = ST_FLUSH;
                        w_cnt_nxt   = c_FL_CNT;
                    end
                end else if (r_state == ST_STALL) begin
                    w_stb      = c_STB_HAZARD;
                    w_hz_cycle = 1'b1;
                    if (r_cnt <= 3'd1) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end else if (w_hz_ex) begin
                    w_stb      = c_STB_HAZARD;
                    w_hz_cycle = 1'b1;
                    if (HAZARD_STALL > 1) begin
                        w_state_nxt = ST_STALL;
                        w_cnt_nxt   = c_HZ_CNT;
                    end
                end else if (w_hz_wb) begin
                    w_stb      = c_STB_HAZARD;
                    w_hz_cycle = 1'b1;
                end else if (halt_req || r_pend) begin
                    w_stb       = c_STB_HALTREQ;
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = c_DRAIN_CNT;
                end else begin
                    w_stb = c_STB_RUN;
                end
            end
            ST_FLUSH: begin
                w_stb      = c_STB_BRANCH;
                w_br_cycle = 1'b1;
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            ST_DRAIN: begin
                w_stb = c_STB_DRAIN;
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = ST_HALTED;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            ST_HALTED: begin
                w_stb = c_STB_HALTED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Halt requests that cannot be serviced immediately are remembered until DRAIN
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_state_nxt == ST_DRAIN && r_state != ST_DRAIN) begin
            w_pend_nxt = 1'b0;
        end else if (halt_req) begin
            w_pend_nxt = 1'b1;
        end
    end

    assign pc_en      = w_stb.pc_en;
    assign ifid_en    = w_stb.ifid_en;
    assign ifid_flush = w_stb.ifid_flush;
    assign idex_flush = w_stb.idex_flush;
    assign exwb_en    = w_stb.exwb_en;
    assign state_o    = r_state;
    assign halted     = (r_state == ST_HALTED);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_hz_cycle && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_br_cycle && r_flush_cnt != 32'hFFFF_FFFF) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    logic w_unused_perf;
    assign w_unused_perf = w_hz_cycle | w_br_cycle;
    assign stall_cnt_o   = 32'd0;
    assign flush_cnt_o   = 32'd0;
`endif

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

    // {state_o, halted, pc_en, ifid_en, ifid_flush, idex_flush, exwb_en}
    localparam logic [8:0] E_IDLE    = {3'd0, 1'b0, 5'b00110};
    localparam logic [8:0] E_RUN     = {3'd1, 1'b0, 5'b11001};
    localparam logic [8:0] E_RUN_HZ  = {3'd1, 1'b0, 5'b00011};
    localparam logic [8:0] E_RUN_BR  = {3'd1, 1'b0, 5'b10111};
    localparam logic [8:0] E_RUN_HLT = {3'd1, 1'b0, 5'b00101};
    localparam logic [8:0] E_STALL   = {3'd2, 1'b0, 5'b00011};
    localparam logic [8:0] E_STL_BR  = {3'd2, 1'b0, 5'b10111};
    localparam logic [8:0] E_FLUSH   = {3'd3, 1'b0, 5'b10111};
    localparam logic [8:0] E_DRAIN   = {3'd4, 1'b0, 5'b00111};
    localparam logic [8:0] E_HALTED  = {3'd5, 1'b1, 5'b00110};

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam logic [31:0] E_STALL_CNT = 32'd6;
    localparam logic [31:0] E_FLUSH_CNT = 32'd2;
    localparam logic [31:0] E_FLUSH_CNT2 = 32'd2;
`else
    localparam logic [31:0] E_STALL_CNT = 32'd0;
    localparam logic [31:0] E_FLUSH_CNT = 32'd0;
    localparam logic [31:0] E_FLUSH_CNT2 = 32'd0;
`endif

    logic        clock = 1'b0;
    logic        reset, start, id_rs_valid, id_rt_valid, ex_regwrite, wb_regwrite;
    logic        br_taken, halt_req;
    logic [5:0]  id_rs, id_rt, ex_rd, wb_rd;
    logic        pc_en, ifid_en, ifid_flush, idex_flush, exwb_en, halted;
    logic [2:0]  state_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.REG_AW(6), .HAZARD_STALL(2), .FLUSH_CYCLES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .id_rs_valid (id_rs_valid),
        .id_rt_valid (id_rt_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_rd       (ex_rd),
        .ex_regwrite (ex_regwrite),
        .wb_rd       (wb_rd),
        .wb_regwrite (wb_regwrite),
        .br_taken    (br_taken),
        .halt_req    (halt_req),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exwb_en     (exwb_en),
        .state_o     (state_o),
        .halted      (halted),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Lets combinational strobes settle on the current inputs, then compares
    task automatic cyc(input string tag, input logic [8:0] exp);
        #1;
        chk(tag, 32'({state_o, halted, pc_en, ifid_en, ifid_flush, idex_flush, exwb_en}),
            32'(exp));
    endtask

    task automatic clr_inputs();
        start = 0; id_rs_valid = 0; id_rt_valid = 0; ex_regwrite = 0; wb_regwrite = 0;
        br_taken = 0; halt_req = 0; id_rs = 0; id_rt = 0; ex_rd = 0; wb_rd = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 0;
        clr_inputs();
        tick(); tick();
        cyc("reset_idle", E_IDLE);
        chk("reset_stall_cnt", stall_cnt_o, 32'd0);
        chk("reset_flush_cnt", flush_cnt_o, 32'd0);

        reset = 1; start = 1;
        cyc("idle_start", E_IDLE);
        tick(); clr_inputs();
        cyc("run", E_RUN);

        // EX hazard: 2 total stall cycles
        id_rs = 5; id_rs_valid = 1; ex_rd = 5; ex_regwrite = 1;
        cyc("hz_ex_c1", E_RUN_HZ);
        tick(); clr_inputs();
        cyc("hz_ex_c2", E_STALL);
        tick();
        cyc("hz_ex_done", E_RUN);

        // WB-only hazard: one cycle, stays in RUN
        id_rt = 9; id_rt_valid = 1; wb_rd = 9; wb_regwrite = 1; ex_rd = 3; ex_regwrite = 1;
        cyc("hz_wb", E_RUN_HZ);
        tick(); clr_inputs();
        cyc("hz_wb_done", E_RUN);

        // Matching address but no write enable
        id_rs = 5; id_rs_valid = 1; ex_rd = 5; ex_regwrite = 0;
        cyc("no_regwrite", E_RUN);

        // Register 0 is not exempt
        clr_inputs();
        id_rs = 0; id_rs_valid = 1; ex_rd = 0; ex_regwrite = 1;
        cyc("hz_r0_c1", E_RUN_HZ);
        tick(); clr_inputs();
        cyc("hz_r0_c2", E_STALL);
        tick();
        cyc("hz_r0_done", E_RUN);

        // Branch in second stall cycle, halt pulsed during FLUSH
        id_rt = 12; id_rt_valid = 1; ex_rd = 12; ex_regwrite = 1;
        cyc("hz3_c1", E_RUN_HZ);
        tick(); clr_inputs(); br_taken = 1;
        cyc("stall_br", E_STL_BR);
        tick(); br_taken = 1; halt_req = 1;
        cyc("flush_ign_br", E_FLUSH);
        tick(); clr_inputs();
        cyc("pend_halt", E_RUN_HLT);
        tick();
        cyc("drain_c1", E_DRAIN);
        tick();
        cyc("drain_c2", E_DRAIN);
        tick();
        cyc("halted", E_HALTED);
        tick(); start = 1; br_taken = 1;
        cyc("halted_sticky", E_HALTED);
        chk("stall_cnt", stall_cnt_o, E_STALL_CNT);
        chk("flush_cnt", flush_cnt_o, E_FLUSH_CNT);

        // Reset mid-STALL
        clr_inputs(); reset = 0;
        tick(); reset = 1; start = 1;
        cyc("rst_idle", E_IDLE);
        tick(); clr_inputs();
        id_rs = 7; id_rs_valid = 1; ex_rd = 7; ex_regwrite = 1;
        cyc("hz_before_rst", E_RUN_HZ);
        tick(); clr_inputs(); reset = 0;
        cyc("stall_before_rst", E_STALL);
        tick(); reset = 1;
        cyc("rst_mid_stall", E_IDLE);
        chk("rst_stall_cnt", stall_cnt_o, 32'd0);
        start = 1;
        tick(); clr_inputs();
        cyc("run_after_rst", E_RUN);

        // Plain branch in RUN, then direct halt
        br_taken = 1;
        cyc("run_br", E_RUN_BR);
        tick(); clr_inputs();
        cyc("flush_c2", E_FLUSH);
        tick();
        cyc("flush_done", E_RUN);
        chk("flush_cnt2", flush_cnt_o, E_FLUSH_CNT2);
        halt_req = 1;
        cyc("run_halt", E_RUN_HLT);
        tick(); clr_inputs();
        cyc("drain2_c1", E_DRAIN);
        tick();
        cyc("drain2_c2", E_DRAIN);
        tick();
        cyc("halted2", E_HALTED);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the SCU ISA pipelined CPU. It detects read-after-write hazards between the ID-stage source registers and the destinations held in the ID/EX and EX/WB buffers. It also handles taken-branch flushes and halt draining. From these it generates the enable and flush strobes that the PC, IF/ID, ID/EX and EX/WB buffers sample on their falling clock edge.

## Interface
Parameters:
- REG_AW, 6: register address width.
- HAZARD_STALL, 2: total bubble cycles for a hazard against the ID/EX destination. Legal range 1..7.
- FLUSH_CYCLES, 2: bubble cycles after a taken branch. Legal range 1..7.

Ports:
- clock, in, 1: single clock. Controller state updates on the rising edge.
- reset, in, 1: synchronous, active-low. Sampled on the rising edge of clock.
- start, in, 1: leave IDLE and begin execution.
- id_rs_valid / id_rt_valid, in, 1 each: the ID instruction reads rs / rt.
- id_rs / id_rt, in, REG_AW each: ID source register addresses.
- ex_rd, in, REG_AW; ex_regwrite, in, 1: ID/EX destination and its write enable.
- wb_rd, in, REG_AW; wb_regwrite, in, 1: EX/WB destination and its write enable.
- br_taken, in, 1: branch resolved taken in EX this cycle.
- halt_req, in, 1: request to stop fetching and drain.
- pc_en, out, 1: PC load enable.
- ifid_en, out, 1: IF/ID load enable.
- ifid_flush, out, 1: IF/ID load bubble.
- idex_flush, out, 1: ID/EX load bubble (RegWrite=0).
- exwb_en, out, 1: EX/WB load enable.
- state_o, out, 3: current state encoding.
- halted, out, 1: high in HALTED.
- stall_cnt_o / flush_cnt_o, out, 32 each: performance counters. Present only under the configuration macro; see Configuration.

## Operation
- States: IDLE=0, RUN=1, STALL=2, FLUSH=3, DRAIN=4, HALTED=5.
- Outputs are decoded combinationally from the state, the down-counter (3 bits) and the current inputs, so a hazard stalls in the cycle it is seen.
- Hazard conditions:
  - hz_ex = ex_regwrite && ((id_rs_valid && id_rs==ex_rd) || (id_rt_valid && id_rt==ex_rd)).
  - hz_wb is the same test against wb_rd / wb_regwrite.
  - No register address is exempt.
- IDLE:
  - pc_en=ifid_en=exwb_en=0; ifid_flush=idex_flush=1.
  - start=1 -> RUN.
- RUN, priority br_taken > hazard > halt:
  - br_taken: pc_en=1, ifid_flush=1, idex_flush=1, exwb_en=1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - hz_ex: pc_en=0, ifid_en=0, idex_flush=1, exwb_en=1. If HAZARD_STALL>1, go to STALL with cnt=HAZARD_STALL-1.
  - hz_wb only: same strobes for one cycle; stay in RUN.
  - halt_req, or pending halt: go to DRAIN with cnt=2; pc_en=0, ifid_flush=1.
  - Otherwise: pc_en=ifid_en=exwb_en=1, both flushes 0.
- STALL:
  - Strobes as for hz_ex.
  - cnt decrements each cycle; cnt==1 -> RUN.
  - br_taken in STALL aborts the stall and performs the RUN br_taken action, since the branch is older.
- FLUSH:
  - Strobes: ifid_flush=1, idex_flush=1, pc_en=1, exwb_en=1.
  - cnt==1 -> RUN.
  - br_taken is ignored, because only bubbles are in EX.
- halt_req outside RUN sets a sticky pending-halt bit. The bit is serviced on the first RUN cycle and cleared on entry to DRAIN.
- DRAIN:
  - pc_en=0, ifid_flush=1, idex_flush=1, exwb_en=1.
  - cnt==1 -> HALTED.
- HALTED: all enables 0, both flushes 1, halted=1. Only reset leaves HALTED.

## Timing
- Reset, with reset=0 at a rising edge: state=IDLE, cnt=0, pending-halt=0, perf counters=0.
  - Outputs then read pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, exwb_en=0, state_o=0, halted=0.
- Reset asserted mid-STALL, mid-FLUSH or mid-DRAIN returns to IDLE at that edge. No residual count survives.
- Strobe latency is zero cycles, combinational within the cycle. Inputs must be settled before the falling edge at which the buffers sample.
- Total hz_ex stall is exactly HAZARD_STALL cycles. Total flush is exactly FLUSH_CYCLES cycles. Drain is exactly 2 cycles.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined:
  - stall_cnt_o increments on each cycle with idex_flush=1 due to a hazard.
  - flush_cnt_o increments on each branch-flush cycle.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Macro undefined: both ports exist but are tied to 32'b0, and no counter flops are inferred.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (3-bit);
  - REG_AW_DEF=6;
  - a strobe struct {pc_en, ifid_en, ifid_flush, idex_flush, exwb_en}.
- Sub-module hazard_detect holds the purely combinational hz_ex / hz_wb compare, reusable by forwarding logic. The FSM stays in pipe_hazard_ctrl.

## Test plan
- Reset and start: reset=0 for 2 cycles gives the IDLE strobes. start=1 gives RUN with all enables=1 on the next cycle.
- EX hazard: id_rs=5, rs_valid=1, ex_rd=5, ex_regwrite=1 -> pc_en=0 and idex_flush=1 for exactly 2 cycles, then RUN.
- WB-only hazard: id_rt=9 matches wb_rd=9 with wb_regwrite=1 and no EX match -> 1 stall cycle. The hz_ex case with ex_regwrite=0 gives no stall.
- Branch during stall: br_taken=1 in the 2nd STALL cycle -> FLUSH strobes with pc_en=1 for 2 cycles, then RUN.
- Halt pending: halt_req pulsed in FLUSH -> DRAIN for 2 cycles after the return to RUN, then halted=1 and enables 0 until reset=0.
- Perf counters (macro defined): 3 EX hazards and 1 branch -> stall_cnt_o=6 and flush_cnt_o=2. With the macro undefined, both read 0.
